// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg: shared write-through dcache types and line-address geometry.
package wt_cache_pkg;

    localparam int DCACHE_OFFSET_WIDTH = 6;
    localparam int DCACHE_LINE_WIDTH   = 64 - DCACHE_OFFSET_WIDTH;

    typedef struct packed {
        logic                         vld;
        logic                         nc;
        logic [DCACHE_LINE_WIDTH-1:0] line;
    } mshr_t;

endpackage

// File: rtl/wt_dcache_miss_rr.sv
// wt_dcache_miss_rr: picks one eligible port; round-robin from a pointer when
// WT_DCACHE_MISS_ARB_RR_EN is defined, lowest-index fixed priority otherwise.
module wt_dcache_miss_rr #(
    parameter int NumPorts = 3,
    parameter int IdxWidth = $clog2(NumPorts)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] elig_i,
    input  logic                upd_i,
    input  logic [IdxWidth-1:0] upd_idx_i,
    output logic [IdxWidth-1:0] idx_o
);

`ifdef WT_DCACHE_MISS_ARB_RR_EN
    logic [IdxWidth-1:0] ptr_q;
    logic                found;
    int                  cand;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NumPorts; i++) begin
            cand = (int'(ptr_q) + i) % NumPorts;
            if (!found && elig_i[cand]) begin
                found = 1'b1;
                idx_o = IdxWidth'(cand);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            ptr_q <= '0;
        else if (upd_i)
            ptr_q <= (int'(upd_idx_i) == NumPorts - 1) ? '0 : IdxWidth'(int'(upd_idx_i) + 1);
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk_i, rst_ni, upd_i, upd_idx_i};

    always_comb begin
        idx_o = '0;
        for (int i = NumPorts - 1; i >= 0; i--)
            if (elig_i[i]) idx_o = IdxWidth'(i);
    end
`endif

endmodule

// File: rtl/wt_dcache_miss_arb.sv
// wt_dcache_miss_arb: per-port MSHRs, collision replay and miss arbitration onto
// one memory channel. WT_DCACHE_MISS_ARB_RR_EN selects round-robin arbitration.
module wt_dcache_miss_arb
    import wt_cache_pkg::*;
#(
    parameter int NumPorts = 3,
    parameter int TidWidth = $clog2(NumPorts)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumPorts-1:0]      miss_req_i,
    input  logic [NumPorts-1:0][63:0] miss_paddr_i,
    input  logic [NumPorts-1:0]      miss_nc_i,
    input  logic [NumPorts-1:0][2:0] miss_size_i,
    output logic [NumPorts-1:0]      miss_ack_o,
    output logic [NumPorts-1:0]      miss_replay_o,
    output logic [NumPorts-1:0]      miss_rtrn_vld_o,
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    output logic [63:0]              mem_paddr_o,
    output logic [2:0]               mem_size_o,
    output logic                     mem_nc_o,
    output logic [TidWidth-1:0]      mem_tid_o,
    input  logic                     mem_rtrn_vld_i,
    input  logic [TidWidth-1:0]      mem_rtrn_tid_i,
    output logic                     err_o
);

    mshr_t [NumPorts-1:0] mshr_q;
    logic  [NumPorts-1:0] req, vld, elig;
    logic  [TidWidth-1:0] pick_idx, sel, lock_idx_q;
    logic                 lock_q, locked, gnt, rtrn_ok;

    // requests are masked during reset so every output reads zero
    assign req = miss_req_i & {NumPorts{rst_ni}};

    always_comb begin
        miss_replay_o = '0;
        vld           = '0;
        for (int p = 0; p < NumPorts; p++) begin
            vld[p] = mshr_q[p].vld;
            for (int q = 0; q < NumPorts; q++)
                if (q != p && mshr_q[q].vld && !mshr_q[q].nc &&
                    mshr_q[q].line == miss_paddr_i[p][63:DCACHE_OFFSET_WIDTH])
                    miss_replay_o[p] = req[p] && !miss_nc_i[p];
        end
    end

    assign elig = req & ~miss_replay_o & ~vld;

    wt_dcache_miss_rr #(
        .NumPorts (NumPorts),
        .IdxWidth (TidWidth)
    ) i_rr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .elig_i    (elig),
        .upd_i     (gnt),
        .upd_idx_i (sel),
        .idx_o     (pick_idx)
    );

    // a locked port keeps the channel only while it still requests
    assign locked      = lock_q && elig[lock_idx_q];
    assign sel         = locked ? lock_idx_q : pick_idx;
    assign mem_req_o   = locked || (|elig);
    assign gnt         = mem_req_o && mem_gnt_i;
    assign mem_paddr_o = mem_req_o ? miss_paddr_i[sel] : '0;
    assign mem_size_o  = mem_req_o ? miss_size_i[sel] : '0;
    assign mem_nc_o    = mem_req_o && miss_nc_i[sel];
    assign mem_tid_o   = mem_req_o ? sel : '0;
    assign miss_ack_o  = gnt ? NumPorts'(1) << sel : '0;

    assign rtrn_ok         = mem_rtrn_vld_i && rst_ni && int'(mem_rtrn_tid_i) < NumPorts &&
                             vld[mem_rtrn_tid_i];
    assign miss_rtrn_vld_o = rtrn_ok ? NumPorts'(1) << mem_rtrn_tid_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mshr_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_o      <= 1'b0;
        end else begin
            lock_q     <= mem_req_o && !mem_gnt_i;
            lock_idx_q <= sel;
            err_o      <= err_o || (mem_rtrn_vld_i && !rtrn_ok);
            for (int p = 0; p < NumPorts; p++) begin
                if (gnt && int'(sel) == p)
                    mshr_q[p] <= '{vld: 1'b1, nc: miss_nc_i[p],
                                   line: miss_paddr_i[p][63:DCACHE_OFFSET_WIDTH]};
                else if (rtrn_ok && int'(mem_rtrn_tid_i) == p)
                    mshr_q[p].vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wt_dcache_miss_arb.sv
// tb_wt_dcache_miss_arb: directed checks of miss arbitration, replay, lock and returns.
module tb_wt_dcache_miss_arb;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [2:0]       miss_req, miss_nc, miss_ack, miss_replay, miss_rtrn;
    logic [2:0][63:0] miss_paddr;
    logic [2:0][2:0]  miss_size;
    logic             mem_req, mem_gnt, mem_nc, mem_rtrn_vld, err;
    logic [63:0]      mem_paddr;
    logic [2:0]       mem_size;
    logic [1:0]       mem_tid, mem_rtrn_tid;
    int               total = 0;
    int               bad = 0;
    int               order [3];

    always #5 clk_i = ~clk_i;

    wt_dcache_miss_arb dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .miss_req_i      (miss_req),
        .miss_paddr_i    (miss_paddr),
        .miss_nc_i       (miss_nc),
        .miss_size_i     (miss_size),
        .miss_ack_o      (miss_ack),
        .miss_replay_o   (miss_replay),
        .miss_rtrn_vld_o (miss_rtrn),
        .mem_req_o       (mem_req),
        .mem_gnt_i       (mem_gnt),
        .mem_paddr_o     (mem_paddr),
        .mem_size_o      (mem_size),
        .mem_nc_o        (mem_nc),
        .mem_tid_o       (mem_tid),
        .mem_rtrn_vld_i  (mem_rtrn_vld),
        .mem_rtrn_tid_i  (mem_rtrn_tid),
        .err_o           (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
`ifdef WT_DCACHE_MISS_ARB_RR_EN
        order = '{2, 0, 1};
`else
        order = '{0, 1, 2};
`endif
        rst_ni       = 1'b0;
        miss_req     = 3'b111;
        miss_nc      = '0;
        miss_paddr   = '{64'h3000, 64'h2000, 64'h1000};
        miss_size    = '{3'd7, 3'd7, 3'd7};
        mem_gnt      = 1'b1;
        mem_rtrn_vld = 1'b1;
        mem_rtrn_tid = 2'd0;
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'h0);
        chk("rst_ack", 64'(miss_ack), 64'h0);
        chk("rst_replay", 64'(miss_replay), 64'h0);
        chk("rst_rtrn", 64'(miss_rtrn), 64'h0);
        chk("rst_paddr", mem_paddr, 64'h0);
        tick();
        chk("rst_err", 64'(err), 64'h0);
        miss_req     = '0;
        mem_rtrn_vld = 1'b0;
        rst_ni       = 1'b1;
        tick();

        // single miss, zero-cycle grant
        miss_req      = 3'b001;
        miss_paddr[0] = 64'h8000_1040;
        #1;
        chk("single_ack", 64'(miss_ack), 64'h1);
        chk("single_req", 64'(mem_req), 64'h1);
        chk("single_tid", 64'(mem_tid), 64'h0);
        chk("single_paddr", mem_paddr, 64'h8000_1040);
        chk("single_size", 64'(mem_size), 64'h7);
        chk("single_nc", 64'(mem_nc), 64'h0);
        tick();
        #1;
        chk("busy_mshr_ack", 64'(miss_ack), 64'h0);
        chk("busy_mshr_req", 64'(mem_req), 64'h0);
        miss_req = '0;
        tick();
        tick();

        // collision with the pending cacheable line, then non-cacheable bypass
        miss_req      = 3'b010;
        miss_paddr[1] = 64'h8000_1058;
        #1;
        chk("coll_replay", 64'(miss_replay), 64'h2);
        chk("coll_ack", 64'(miss_ack), 64'h0);
        chk("coll_req", 64'(mem_req), 64'h0);
        miss_nc[1] = 1'b1;
        #1;
        chk("nc_replay", 64'(miss_replay), 64'h0);
        chk("nc_ack", 64'(miss_ack), 64'h2);
        chk("nc_tid", 64'(mem_tid), 64'h1);
        chk("nc_flag", 64'(mem_nc), 64'h1);
        tick();
        miss_req     = '0;
        miss_nc      = '0;
        mem_rtrn_vld = 1'b1;
        mem_rtrn_tid = 2'd0;
        #1;
        chk("rtrn0", 64'(miss_rtrn), 64'h1);
        tick();
        mem_rtrn_tid = 2'd1;
        #1;
        chk("rtrn1", 64'(miss_rtrn), 64'h2);
        tick();
        mem_rtrn_vld = 1'b0;
        mem_gnt      = 1'b0;
        miss_req     = 3'b010;
        #1;
        chk("err_clean", 64'(err), 64'h0);
        chk("mshr0_cleared_replay", 64'(miss_replay), 64'h0);
        chk("mshr0_cleared_tid", 64'(mem_tid), 64'h1);
        miss_req = '0;
        mem_gnt  = 1'b1;
        tick();

        // stray return
        mem_rtrn_vld = 1'b1;
        mem_rtrn_tid = 2'd1;
        #1;
        chk("stray_rtrn", 64'(miss_rtrn), 64'h0);
        tick();
        mem_rtrn_vld = 1'b0;
        chk("stray_err", 64'(err), 64'h1);
        tick();
        tick();
        chk("stray_err_sticky", 64'(err), 64'h1);

        // all three ports contend with grant always high
        miss_paddr = '{64'h3000, 64'h2000, 64'h1000};
        miss_req   = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("arb_tid%0d", k), 64'(mem_tid), 64'(order[k]));
            chk($sformatf("arb_ack%0d", k), 64'(miss_ack), 64'(1) << order[k]);
            tick();
            miss_req[order[k]] = 1'b0;
        end
        mem_rtrn_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_rtrn_tid = 2'(k);
            #1;
            chk($sformatf("arb_rtrn%0d", k), 64'(miss_rtrn), 64'(1) << k);
            tick();
        end
        mem_rtrn_vld = 1'b0;

        // lock on port 2 while port 0 also requests
        mem_gnt  = 1'b0;
        miss_req = 3'b100;
        #1;
        chk("lock_first_tid", 64'(mem_tid), 64'h2);
        tick();
        miss_req = 3'b101;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("lock_tid%0d", k), 64'(mem_tid), 64'h2);
            chk($sformatf("lock_ack%0d", k), 64'(miss_ack), 64'h0);
            tick();
        end
        mem_gnt = 1'b1;
        #1;
        chk("lock_gnt_ack", 64'(miss_ack), 64'h4);
        tick();
        miss_req = 3'b001;
        #1;
        chk("after_lock_ack", 64'(miss_ack), 64'h1);
        tick();
        miss_req     = '0;
        mem_rtrn_vld = 1'b1;
        mem_rtrn_tid = 2'd2;
        tick();
        mem_rtrn_tid = 2'd0;
        tick();
        mem_rtrn_vld = 1'b0;

        // kill while locked
        mem_gnt  = 1'b0;
        miss_req = 3'b010;
        #1;
        chk("kill_sel", 64'(mem_tid), 64'h1);
        tick();
        miss_req = 3'b011;
        #1;
        chk("kill_locked_tid", 64'(mem_tid), 64'h1);
        tick();
        miss_req = 3'b001;
        mem_gnt  = 1'b1;
        #1;
        chk("kill_ack", 64'(miss_ack), 64'h1);
        chk("kill_tid", 64'(mem_tid), 64'h0);
        tick();

        // return and collision in the same cycle: replay stays conservative
        miss_req      = 3'b010;
        miss_paddr[1] = 64'h1020;
        mem_rtrn_vld  = 1'b1;
        mem_rtrn_tid  = 2'd0;
        #1;
        chk("rtrn_coll_replay", 64'(miss_replay), 64'h2);
        chk("rtrn_coll_rtrn", 64'(miss_rtrn), 64'h1);
        chk("rtrn_coll_ack", 64'(miss_ack), 64'h0);
        tick();
        mem_rtrn_vld = 1'b0;
        #1;
        chk("post_rtrn_replay", 64'(miss_replay), 64'h0);
        chk("post_rtrn_ack", 64'(miss_ack), 64'h2);
        tick();
        miss_req = '0;

        // reset mid-transaction drops MSHR1
        rst_ni = 1'b0;
        #1;
        chk("midrst_err", 64'(err), 64'h0);
        tick();
        rst_ni       = 1'b1;
        mem_rtrn_vld = 1'b1;
        mem_rtrn_tid = 2'd1;
        #1;
        chk("midrst_rtrn", 64'(miss_rtrn), 64'h0);
        tick();
        mem_rtrn_vld = 1'b0;
        chk("midrst_stray_err", 64'(err), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
